// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-level controller in front of the 8-bit combinational ALU.
// Issues ADD/SUB/AND as a single ALU pass, and MUL as DATA_WIDTH shift-add passes
// through the ALU adder. The result and flags are held in a valid/ready response register.
// Optional build macro ALU_OP_SEQUENCER_CMD_BUF_EN adds a one-entry command buffer.
// This buffer lets a command queued while busy launch straight out of DONE.
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 8,  // system operand width (param.v default)
  parameter int OP_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_W-1:0]       cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic [OP_W-1:0]       alu_sel,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_z,
  input  logic [DATA_WIDTH-1:0] alu_flag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_lo,
  output logic [DATA_WIDTH-1:0] rsp_hi,
  output logic                  rsp_carry,
  output logic                  rsp_zero,
  output logic                  rsp_err
);

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(4);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t                state;
  logic [OP_W-1:0]       op_r;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] mq;
  logic [CNT_W-1:0]      cnt;

  logic                  fire;
  logic                  ld_en;
  logic [OP_W-1:0]       ld_op;
  logic [DATA_WIDTH-1:0] ld_a;
  logic [DATA_WIDTH-1:0] ld_b;
  logic                  ld_legal;
  logic                  op_legal;
  logic [DATA_WIDTH-1:0] acc_n;
  logic [DATA_WIDTH-1:0] mq_n;
  logic                  unused_flag_bits;

  assign unused_flag_bits = ^alu_flag[DATA_WIDTH-1:1];

`ifdef ALU_OP_SEQUENCER_CMD_BUF_EN
  logic                  buf_full;
  logic [OP_W-1:0]       buf_op;
  logic [DATA_WIDTH-1:0] buf_a;
  logic [DATA_WIDTH-1:0] buf_b;
  logic                  buf_set;
  logic                  buf_clr;

  assign cmd_ready = !buf_full;
`endif

  assign fire = cmd_valid & cmd_ready;

  // Launch decision: which command (if any) starts on this edge, and buffer fill/drain
  always_comb begin
    ld_en = 1'b0;
    ld_op = cmd_op;
    ld_a  = cmd_a;
    ld_b  = cmd_b;
`ifdef ALU_OP_SEQUENCER_CMD_BUF_EN
    buf_set = 1'b0;
    buf_clr = 1'b0;
    case (state)
      S_IDLE: ld_en = fire;
      S_DONE: begin
        if (rsp_ready) begin
          // A buffered command has priority; a simultaneous new one refills the buffer
          if (buf_full) begin
            ld_en   = 1'b1;
            ld_op   = buf_op;
            ld_a    = buf_a;
            ld_b    = buf_b;
            buf_clr = 1'b1;
            buf_set = fire;
          end else begin
            ld_en = fire;
          end
        end else begin
          buf_set = fire;
        end
      end
      default: buf_set = fire;
    endcase
`else
    if (state == S_IDLE) ld_en = fire;
`endif
    ld_legal = (ld_op == OP_ADD) || (ld_op == OP_SUB) || (ld_op == OP_AND);
    op_legal = (op_r == OP_ADD) || (op_r == OP_SUB) || (op_r == OP_AND);
    // Shift the 9-bit adder result {carry, z} right into acc/mq
    acc_n = {alu_flag[0], alu_z[DATA_WIDTH-1:1]};
    mq_n  = {alu_z[0], mq[DATA_WIDTH-1:1]};
  end

  // Sequencer FSM with registered ALU drive and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_r      <= '0;
      a_r       <= '0;
      acc       <= '0;
      mq        <= '0;
      cnt       <= '0;
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_lo    <= '0;
      rsp_hi    <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
`ifdef ALU_OP_SEQUENCER_CMD_BUF_EN
      buf_full  <= 1'b0;
      buf_op    <= '0;
      buf_a     <= '0;
      buf_b     <= '0;
`else
      cmd_ready <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: ;
        S_EXEC: begin
          rsp_lo    <= op_legal ? alu_z : '0;
          rsp_hi    <= '0;
          rsp_carry <= ((op_r == OP_ADD) || (op_r == OP_SUB)) ? alu_flag[0] : 1'b0;
          rsp_zero  <= op_legal && (alu_z == '0);
          rsp_err   <= !op_legal;
          rsp_valid <= 1'b1;
          alu_sel   <= '0;
          alu_a     <= '0;
          alu_b     <= '0;
          state     <= S_DONE;
        end
        S_MUL: begin
          acc   <= acc_n;
          mq    <= mq_n;
          cnt   <= cnt + 1'b1;
          alu_a <= acc_n;
          alu_b <= mq_n[0] ? a_r : '0;
          if (cnt == CNT_LAST) begin
            rsp_hi    <= acc_n;
            rsp_lo    <= mq_n;
            rsp_carry <= (acc_n != '0);
            rsp_zero  <= ({acc_n, mq_n} == '0);
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            alu_sel   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
`ifndef ALU_OP_SEQUENCER_CMD_BUF_EN
            cmd_ready <= 1'b1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase

      // Launch overrides the per-state updates above (covers IDLE and DONE->EXEC/MUL)
      if (ld_en) begin
        op_r <= ld_op;
        a_r  <= ld_a;
        acc  <= '0;
        mq   <= ld_b;
        cnt  <= '0;
        if (ld_op == OP_MUL) begin
          state   <= S_MUL;
          alu_sel <= OP_ADD;
          alu_a   <= '0;
          alu_b   <= ld_b[0] ? ld_a : '0;
        end else begin
          state   <= S_EXEC;
          alu_sel <= ld_legal ? ld_op : OP_NOP;
          alu_a   <= ld_a;
          alu_b   <= ld_b;
        end
`ifndef ALU_OP_SEQUENCER_CMD_BUF_EN
        cmd_ready <= 1'b0;
`endif
      end

`ifdef ALU_OP_SEQUENCER_CMD_BUF_EN
      if (buf_set) begin
        buf_full <= 1'b1;
        buf_op   <= cmd_op;
        buf_a    <= cmd_a;
        buf_b    <= cmd_b;
      end else if (buf_clr) begin
        buf_full <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural 8-bit ALU plus directed vector table
// and hand-written sequences for backpressure, mid-operation reset and the command buffer.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [3:0] alu_sel;
  logic [7:0] alu_a, alu_b, alu_z, alu_flag;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_lo, rsp_hi;
  logic       rsp_carry, rsp_zero, rsp_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_WIDTH(8), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_z(alu_z), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Combinational ALU the sequencer drives: flag[0] = carry (ADD) / borrow (SUB)
  always_comb begin
    alu_z    = '0;
    alu_flag = '0;
    case (alu_sel)
      4'd1: {alu_flag[0], alu_z} = {1'b0, alu_a} + {1'b0, alu_b};
      4'd2: begin
        alu_z       = alu_a - alu_b;
        alu_flag[0] = (alu_a < alu_b);
      end
      4'd3: alu_z = alu_a & alu_b;
      default: ;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef ALU_OP_SEQUENCER_CMD_BUF_EN
  localparam logic BUSY_READY = 1'b1;
`else
  localparam logic BUSY_READY = 1'b0;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one command from IDLE; returns at the negedge where rsp_valid is first seen
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [3:0] sel_seen, output logic rdy_seen);
    @(negedge clk);
    check("hs_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat      = 0;
    sel_seen = '0;
    rdy_seen = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      sel_seen |= alu_sel;
      rdy_seen |= cmd_ready;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("post_rsp_valid", rsp_valid, 1'b0);
    check("post_rsp_cmd_ready", cmd_ready, 1'b1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, lo, hi;
    logic       c, z, e;
    logic [3:0] sel;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int         lat;
    logic [3:0] sel_seen;
    logic       rdy_seen;
    logic       seen;

    vecs[0]  = '{4'h1, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 4'h1, 2};
    vecs[1]  = '{4'h3, 8'hAA, 8'h55, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 4'h3, 2};
    vecs[2]  = '{4'h2, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 4'h2, 2};
    vecs[3]  = '{4'h4, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 4'h1, 9};
    vecs[4]  = '{4'h4, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 4'h1, 9};
    vecs[5]  = '{4'hF, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 2};
    vecs[6]  = '{4'h2, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 4'h2, 2};
    vecs[7]  = '{4'h4, 8'h0D, 8'h0B, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 4'h1, 9};
    vecs[8]  = '{4'h1, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 4'h1, 2};
    vecs[9]  = '{4'h4, 8'h10, 8'h10, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 4'h1, 9};
    vecs[10] = '{4'h0, 8'h21, 8'h43, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 2};
    vecs[11] = '{4'h4, 8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 4'h1, 9};

    // Reset state
    #12;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp", {rsp_lo, rsp_hi}, 16'h0000);
    check("rst_flags", {rsp_carry, rsp_zero, rsp_err}, 3'b000);
    check("rst_alu", {alu_sel, alu_a[3:0], alu_b[3:0]}, 12'h000);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, lat, sel_seen, rdy_seen);
      check($sformatf("v%0d_latency", i), 16'(lat), 16'(vecs[i].lat));
      check($sformatf("v%0d_lo", i), rsp_lo, vecs[i].lo);
      check($sformatf("v%0d_hi", i), rsp_hi, vecs[i].hi);
      check($sformatf("v%0d_carry", i), rsp_carry, vecs[i].c);
      check($sformatf("v%0d_zero", i), rsp_zero, vecs[i].z);
      check($sformatf("v%0d_err", i), rsp_err, vecs[i].e);
      check($sformatf("v%0d_alu_sel", i), sel_seen, vecs[i].sel);
      check($sformatf("v%0d_busy_ready", i), rdy_seen, BUSY_READY);
      finish_rsp();
    end

    // Backpressure: response held stable for 5 cycles
    run_cmd(4'h1, 8'h33, 8'h44, lat, sel_seen, rdy_seen);
    check("bp_latency", 16'(lat), 16'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_lo", {rsp_lo, rsp_hi}, 16'h7700);
      check("bp_flags", {rsp_carry, rsp_zero, rsp_err}, 3'b000);
      check("bp_cmd_ready", cmd_ready, BUSY_READY);
    end
    finish_rsp();

    // Asynchronous reset during MUL iteration 4: no response afterwards
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'h4; cmd_a = 8'hFF; cmd_b = 8'hFF;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_rsp_valid", rsp_valid, 1'b0);
    check("mrst_cmd_ready", cmd_ready, 1'b1);
    check("mrst_alu", {alu_sel, alu_a, alu_b}, 20'h00000);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    check("mrst_no_rsp", seen, 1'b0);
    run_cmd(4'h1, 8'h01, 8'h01, lat, sel_seen, rdy_seen);
    check("mrst_add_latency", 16'(lat), 16'd2);
    check("mrst_add_lo", rsp_lo, 8'h02);
    finish_rsp();

`ifdef ALU_OP_SEQUENCER_CMD_BUF_EN
    // MUL then ADD back to back through the command buffer
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'h4; cmd_a = 8'h0D; cmd_b = 8'h0B;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("buf_ready_empty", cmd_ready, 1'b1);
    cmd_op = 4'h1; cmd_a = 8'h05; cmd_b = 8'h06;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("buf_ready_full", cmd_ready, 1'b0);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("buf_mul_latency", 16'(lat), 16'd7);
    check("buf_mul_rsp", {rsp_hi, rsp_lo}, 16'h008F);
    @(posedge clk);
    @(negedge clk);
    check("buf_gap_valid", rsp_valid, 1'b0);
    check("buf_ready_drained", cmd_ready, 1'b1);
    @(negedge clk);
    check("buf_add_valid", rsp_valid, 1'b1);
    check("buf_add_rsp", {rsp_hi, rsp_lo}, 16'h000B);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("buf_end_valid", rsp_valid, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-level controller in front of the 8-bit combinational ALU (sel/a/b in, z/flag out). Accepts one operation per valid/ready handshake and drives the ALU select and operand lines. Registers the result and flags into a response handshake. Also sequences a multi-cycle unsigned multiply as 8 shift-add iterations through the ALU adder, so the CPU gets MUL without a dedicated multiplier.

Parameters:
DATA_WIDTH, `DATA_WIDTH (8, from param.v), operand/result width
OP_W, 4, opcode width (matches ALU sel)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept command
cmd_op  input  OP_W  0001 ADD, 0010 SUB, 0011 AND, 0100 MUL, others illegal
cmd_a  input  DATA_WIDTH  operand A
cmd_b  input  DATA_WIDTH  operand B
alu_sel  output  OP_W  to ALU sel
alu_a  output  DATA_WIDTH  to ALU a
alu_b  output  DATA_WIDTH  to ALU b
alu_z  input  DATA_WIDTH  from ALU z
alu_flag  input  DATA_WIDTH  from ALU flag; bit0 = carry/borrow
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_lo  output  DATA_WIDTH  result (MUL low byte)
rsp_hi  output  DATA_WIDTH  MUL high byte; 0 for other ops
rsp_carry  output  1  carry flag
rsp_zero  output  1  zero flag
rsp_err  output  1  illegal opcode

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, all rsp_* = 0, alu_sel=0000, alu_a=alu_b=0. Internal registers cleared.
- Reset mid-operation: the operation is abandoned and no response is produced. cmd_ready=1 on the first clk edge after rst deasserts.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE:
  - cmd_ready=1 and ALU is driven with sel=0000.
  - On cmd_valid&cmd_ready, latch op/a/b.
  - Go to MUL if op=0100, else EXEC.
- EXEC (1 cycle):
  - Drive alu_sel=op, alu_a=A, alu_b=B. Capture alu_z into rsp_lo and set rsp_hi=0.
  - Carry: alu_flag[0] for ADD/SUB, 0 for AND.
  - Zero: (rsp_lo==0).
  - Illegal op: drive alu_sel=0000. Result: rsp_lo=0, carry=0, zero=0, err=1.
  - Go to DONE.
- MUL (exactly 8 cycles, iteration counter 0..7):
  - Registers: acc (high byte, init 0) and mq (init B); multiplicand is A.
  - Each cycle: drive alu_sel=0001, alu_a=acc, alu_b = mq[0] ? A : 0. Then acc <= {alu_flag[0], alu_z[7:1]} and mq <= {alu_z[0], mq[7:1]}.
  - After the 8th iteration: rsp_hi=acc, rsp_lo=mq.
  - Carry = (rsp_hi != 0); zero = ({hi,lo}==0).
  - Go to DONE.
- DONE:
  - rsp_valid=1. All rsp_* held stable until rsp_valid&rsp_ready.
  - Then go to IDLE; cmd_ready=1 the following cycle.
- Latency, with handshake at edge t:
  - ADD/SUB/AND/illegal: rsp_valid from t+2.
  - MUL: rsp_valid from t+9.
- cmd_ready=0 in EXEC, MUL, DONE unless the optional feature is enabled.
- ALU outputs change only on clk edges (registered), except in IDLE where they are constant 0.
- Width: all arithmetic is modulo 2^DATA_WIDTH. MUL is unsigned 8x8 -> 16.

Optional Feature:
- Macro: ALU_OP_SEQUENCER_CMD_BUF_EN.
- Enabled:
  - One-entry command buffer (op/a/b plus full bit). cmd_ready = !buf_full in every state.
  - A command accepted while busy is stored. It is launched on the same edge that DONE completes (rsp_valid&rsp_ready), going directly to EXEC/MUL with no IDLE cycle.
  - Simultaneous buffer fill and launch in the same cycle: the buffered entry launches and the new command occupies the buffer.
  - rst clears the buffer.
- Disabled: no buffer; cmd_ready as above.

Test Plan:
- ADD A=0xF0, B=0x20 -> rsp_lo=0x10, hi=0x00, carry=1, zero=0, err=0, rsp_valid at t+2.
- AND A=0xAA, B=0x55 -> rsp_lo=0x00, carry=0, zero=1. SUB A=0x05, B=0x05 -> rsp_lo=0x00, zero=1, carry equals ALU flag[0].
- MUL A=0xFF, B=0xFF -> hi=0xFE, lo=0x01, carry=1, zero=0 at t+9. MUL A=0x00, B=0x37 -> hi=lo=0, zero=1, carry=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, cmd_ready=0 (feature off). Response accepted when rsp_ready=1; cmd_ready=1 the next cycle.
- Illegal op 1111, A=0x12 -> alu_sel stays 0000, rsp_err=1, rsp_lo=0, flags 0, t+2. Assert rst asynchronously in MUL iteration 4 -> outputs reset immediately, no response; a following ADD 0x01+0x01 -> 0x02.
- With ALU_OP_SEQUENCER_CMD_BUF_EN: issue MUL then ADD back-to-back, rsp_ready=1 -> MUL response, then ADD response 2 cycles after the MUL handshake. cmd_ready=0 only while the buffer is full.
